// File: rtl/fetch_dispatch_pkg.sv
// Shared definitions for the fetch instruction dispatcher: opcodes, FSM
// encoding and the 64-bit instruction field layout.
package fetch_dispatch_pkg;

  localparam logic [7:0] OP_FEATURE = 8'h01;
  localparam logic [7:0] OP_WEIGHT  = 8'h02;
  localparam logic [7:0] OP_SCALER  = 8'h03;

  // Every instruction field is one byte wide; these are their LSB positions.
  localparam int unsigned FIELD_W     = 8;
  localparam int unsigned OPCODE_LSB  = 56;
  localparam int unsigned FTYPE_LSB   = 48;
  localparam int unsigned SADDRH_LSB  = 40;
  localparam int unsigned SADDRL_LSB  = 32;
  localparam int unsigned DADDRH_LSB  = 24;
  localparam int unsigned DADDRL_LSB  = 16;
  localparam int unsigned MEMSEL_LSB  = 8;
  localparam int unsigned COUNTER_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    OPK_FEATURE,
    OPK_WEIGHT,
    OPK_SCALER,
    OPK_ILLEGAL
  } op_kind_t;

  // Extract one byte-wide field starting at bit position lsb.
  function automatic logic [FIELD_W-1:0] inst_field(input logic [63:0] data,
                                                     input int unsigned lsb);
    logic [63:0] shifted;
    shifted = data >> lsb;
    return shifted[FIELD_W-1:0];
  endfunction

  // Classify a raw opcode byte.
  function automatic op_kind_t decode_op(input logic [7:0] opcode);
    case (opcode)
      OP_FEATURE: return OPK_FEATURE;
      OP_WEIGHT:  return OPK_WEIGHT;
      OP_SCALER:  return OPK_SCALER;
      default:    return OPK_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Loadable, saturating down-counter used as the WAIT-state watchdog.
module fetch_watchdog #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // Load has priority over decrement; the count never wraps below zero.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/fetch_inst_dispatch.sv
// Fetch instruction dispatcher: accepts one 64-bit instruction at a time,
// pulses the matching fetch enable, waits for completion (or a watchdog
// expiry) and acknowledges with a one-cycle inst_done.
module fetch_inst_dispatch
  import fetch_dispatch_pkg::*;
#(
  parameter int unsigned DONE_TIMEOUT = 1023,
  parameter int unsigned SCALER_LAT   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  output logic        inst_ready,
  input  logic [63:0] inst_data,
  output logic        feature_fetch_enable,
  output logic        weight_fetch_enable,
  output logic        scaler_fetch_enable,
  output logic [7:0]  fetch_type,
  output logic [15:0] src_addr,
  output logic [7:0]  dst_addr,
  output logic [7:0]  mem_sel,
  output logic [7:0]  fetch_counter,
  input  logic        feature_fetch_done,
  input  logic        weight_fetch_done,
  output logic        inst_done,
  output logic        busy,
  output logic        illegal_op,
  output logic        timeout_err,
  input  logic        err_clr
);

  localparam int unsigned WD_W = $clog2(DONE_TIMEOUT + 1);
  // The watchdog holds the number of WAIT cycles still to come after the
  // current one, so zero marks the final permitted WAIT cycle.
  localparam logic [WD_W-1:0] LOAD_FETCH  = WD_W'(DONE_TIMEOUT - 1);
  localparam logic [WD_W-1:0] LOAD_SCALER = WD_W'(SCALER_LAT - 1);

  state_t    state, next_state;
  op_kind_t  op_q;
  op_kind_t  in_op;
  logic      accept;
  logic      unit_done;
  logic      wd_zero;
  logic      timeout_hit;
  logic      daddrh_unused;

  assign in_op  = decode_op(inst_field(inst_data, OPCODE_LSB));
  assign accept = (state == ST_IDLE) && inst_valid;

  // Only the done line of the unit that was commanded counts.
  assign unit_done = ((op_q == OPK_FEATURE) && feature_fetch_done) ||
                     ((op_q == OPK_WEIGHT)  && weight_fetch_done);

  // A done arriving on the expiry cycle wins; scaler expiry is normal.
  assign timeout_hit = (state == ST_WAIT) && wd_zero && !unit_done &&
                       (op_q != OPK_SCALER);

  // daddrh has no destination downstream.
  assign daddrh_unused = ^inst_field(inst_data, DADDRH_LSB);

  fetch_watchdog #(
    .WIDTH (WD_W)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .load     (state == ST_ISSUE),
    .load_val ((op_q == OPK_SCALER) ? LOAD_SCALER : LOAD_FETCH),
    .dec      (state == ST_WAIT),
    .zero     (wd_zero)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= next_state;
  end

  // Next-state logic.
  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (inst_valid) next_state = (in_op == OPK_ILLEGAL) ? ST_DONE : ST_ISSUE;
      ST_ISSUE: next_state = ST_WAIT;
      ST_WAIT:  if (unit_done || wd_zero) next_state = ST_DONE;
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Control outputs registered from the next state so they are glitch-free
  // and have no combinational path from any input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      feature_fetch_enable <= 1'b0;
      weight_fetch_enable  <= 1'b0;
      scaler_fetch_enable  <= 1'b0;
      inst_done            <= 1'b0;
      busy                 <= 1'b0;
      inst_ready           <= 1'b0;
    end else begin
      feature_fetch_enable <= accept && (in_op == OPK_FEATURE);
      weight_fetch_enable  <= accept && (in_op == OPK_WEIGHT);
      scaler_fetch_enable  <= accept && (in_op == OPK_SCALER);
      inst_done            <= (next_state == ST_DONE);
      busy                 <= (next_state != ST_IDLE);
      inst_ready           <= (next_state == ST_IDLE);
    end
  end

  // Operand fields and opcode class, captured only on accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q          <= OPK_ILLEGAL;
      fetch_type    <= '0;
      src_addr      <= '0;
      dst_addr      <= '0;
      mem_sel       <= '0;
      fetch_counter <= '0;
    end else if (accept) begin
      op_q          <= in_op;
      fetch_type    <= inst_field(inst_data, FTYPE_LSB);
      src_addr      <= {inst_field(inst_data, SADDRH_LSB), inst_field(inst_data, SADDRL_LSB)};
      dst_addr      <= inst_field(inst_data, DADDRL_LSB);
      mem_sel       <= inst_field(inst_data, MEMSEL_LSB);
      fetch_counter <= inst_field(inst_data, COUNTER_LSB);
    end
  end

  // Sticky error flags; clear beats a simultaneous set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      illegal_op  <= 1'b0;
      timeout_err <= 1'b0;
    end else if (err_clr) begin
      illegal_op  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (accept && (in_op == OPK_ILLEGAL)) illegal_op <= 1'b1;
      if (timeout_hit)                      timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_inst_dispatch.sv
// Self-checking bench for fetch_inst_dispatch: directed scenarios followed by
// random instructions, all compared against a cycle-count reference model.
module tb_fetch_inst_dispatch;

  localparam int TO = 15;
  localparam int SL = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inst_valid = 1'b0;
  logic        inst_ready;
  logic [63:0] inst_data = '0;
  logic        feature_fetch_enable;
  logic        weight_fetch_enable;
  logic        scaler_fetch_enable;
  logic [7:0]  fetch_type;
  logic [15:0] src_addr;
  logic [7:0]  dst_addr;
  logic [7:0]  mem_sel;
  logic [7:0]  fetch_counter;
  logic        feature_fetch_done = 1'b0;
  logic        weight_fetch_done = 1'b0;
  logic        inst_done;
  logic        busy;
  logic        illegal_op;
  logic        timeout_err;
  logic        err_clr = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  bit ill_m = 1'b0;
  bit to_m  = 1'b0;

  fetch_inst_dispatch #(
    .DONE_TIMEOUT (TO),
    .SCALER_LAT   (SL)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .inst_valid           (inst_valid),
    .inst_ready           (inst_ready),
    .inst_data            (inst_data),
    .feature_fetch_enable (feature_fetch_enable),
    .weight_fetch_enable  (weight_fetch_enable),
    .scaler_fetch_enable  (scaler_fetch_enable),
    .fetch_type           (fetch_type),
    .src_addr             (src_addr),
    .dst_addr             (dst_addr),
    .mem_sel              (mem_sel),
    .fetch_counter        (fetch_counter),
    .feature_fetch_done   (feature_fetch_done),
    .weight_fetch_done    (weight_fetch_done),
    .inst_done            (inst_done),
    .busy                 (busy),
    .illegal_op           (illegal_op),
    .timeout_err          (timeout_err),
    .err_clr              (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Everything that must read zero while reset is held.
  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, inst_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_en"}, {feature_fetch_enable, weight_fetch_enable, scaler_fetch_enable}, 0);
    check({tag, "_done"}, inst_done, 0);
    check({tag, "_ops"}, {fetch_type, src_addr, dst_addr, mem_sel, fetch_counter}, 0);
    check({tag, "_flags"}, {illegal_op, timeout_err}, 0);
  endtask

  // Issue one instruction and check every cycle until the dispatcher is idle.
  // done_w: WAIT cycle (1-based) in which the selected unit raises done, or
  // -1 to withhold it. noise: random stray done pulses that must be ignored.
  task automatic run_inst(input string name, input logic [63:0] data, input int done_w,
                          input bit noise, input bit clr_at_accept);
    int kind;
    int done_j;
    bit timed_out;
    logic [47:0] ops_exp;
    // Reference model: cycle j counts from the accept edge.
    case (data[63:56])
      8'h01:   kind = 1;
      8'h02:   kind = 2;
      8'h03:   kind = 3;
      default: kind = 0;
    endcase
    timed_out = 1'b0;
    if (kind == 0)                        done_j = 1;
    else if (kind == 3)                   done_j = SL + 2;
    else if (done_w >= 1 && done_w <= TO) done_j = done_w + 2;
    else begin
      done_j    = TO + 2;
      timed_out = 1'b1;
    end
    ops_exp = {data[55:48], data[47:32], data[23:16], data[15:8], data[7:0]};

    check({name, "_ready_in"}, inst_ready, 1);
    inst_data  = data;
    inst_valid = 1'b1;
    err_clr    = clr_at_accept;
    tick();
    inst_valid = 1'b0;
    err_clr    = 1'b0;
    inst_data  = {$urandom, $urandom};
    if (clr_at_accept) begin
      ill_m = 1'b0;
      to_m  = 1'b0;
    end else if (kind == 0) begin
      ill_m = 1'b1;
    end

    for (int j = 1; j <= done_j + 1; j++) begin
      bit r0, r1;
      if (timed_out && j == done_j) to_m = 1'b1;
      check($sformatf("%s_fe@%0d", name, j), feature_fetch_enable, (j == 1 && kind == 1));
      check($sformatf("%s_we@%0d", name, j), weight_fetch_enable, (j == 1 && kind == 2));
      check($sformatf("%s_se@%0d", name, j), scaler_fetch_enable, (j == 1 && kind == 3));
      check($sformatf("%s_done@%0d", name, j), inst_done, (j == done_j));
      check($sformatf("%s_busy@%0d", name, j), busy, (j <= done_j));
      check($sformatf("%s_ready@%0d", name, j), inst_ready, (j > done_j));
      check($sformatf("%s_ops@%0d", name, j), {fetch_type, src_addr, dst_addr, mem_sel, fetch_counter}, ops_exp);
      check($sformatf("%s_ill@%0d", name, j), illegal_op, ill_m);
      check($sformatf("%s_to@%0d", name, j), timeout_err, to_m);

      feature_fetch_done = 1'b0;
      weight_fetch_done  = 1'b0;
      if (j <= done_j) begin
        r0 = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        r1 = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        case (kind)
          1: begin
            weight_fetch_done = r1;
            if (j == 1 || j == done_j) feature_fetch_done = r0;
            if (j == done_w + 1) feature_fetch_done = 1'b1;
          end
          2: begin
            feature_fetch_done = r0;
            if (j == 1 || j == done_j) weight_fetch_done = r1;
            if (j == done_w + 1) weight_fetch_done = 1'b1;
          end
          default: begin
            feature_fetch_done = r0;
            weight_fetch_done  = r1;
          end
        endcase
        tick();
      end
    end
    feature_fetch_done = 1'b0;
    weight_fetch_done  = 1'b0;
  endtask

  initial begin
    // Reset state, then release.
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b1;
    tick();
    check("post_reset_ready", inst_ready, 1);
    check("post_reset_busy", busy, 0);

    // Feature fetch, done 10 cycles after the enable.
    run_inst("feature", 64'h01_00_12_34_00_05_01_08, 10, 1'b0, 1'b0);

    // Weight fetch with stray feature dones.
    run_inst("weight", 64'h02_07_00_40_AA_11_02_10, 3, 1'b1, 1'b0);

    // Scaler fetch, no done inputs.
    run_inst("scaler", 64'h03_01_56_78_00_22_03_04, -1, 1'b0, 1'b0);

    // Illegal opcode, then clear.
    run_inst("illegal", 64'hFF_02_9A_BC_00_33_04_05, -1, 1'b0, 1'b0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    ill_m = 1'b0;
    to_m  = 1'b0;
    check("err_clr_ill", illegal_op, 0);
    check("err_clr_ready", inst_ready, 1);

    // Timeout with done withheld, then a late done in IDLE.
    run_inst("timeout", 64'h01_03_DE_AD_00_44_05_06, -1, 1'b0, 1'b0);
    feature_fetch_done = 1'b1;
    tick();
    feature_fetch_done = 1'b0;
    check("late_done_busy", busy, 0);
    check("late_done_inst_done", inst_done, 0);
    tick();
    check("late_done_inst_done2", inst_done, 0);
    run_inst("after_to", 64'h01_04_BE_EF_00_55_06_07, 2, 1'b0, 1'b0);

    // Boundaries: done on the expiry cycle, one past it, minimum turnaround.
    run_inst("done_at_expiry", 64'h01_05_00_01_00_66_07_08, TO, 1'b0, 1'b0);
    run_inst("done_past_expiry", 64'h02_06_00_02_00_77_08_09, TO + 1, 1'b0, 1'b0);
    run_inst("min_turn", 64'h02_07_00_03_00_88_09_0A, 1, 1'b1, 1'b0);

    // Clear beats a simultaneous illegal set (and wipes the pending timeout).
    run_inst("clr_prio", 64'h7E_08_00_04_00_99_0A_0B, -1, 1'b0, 1'b1);

    // Reset in the middle of WAIT.
    inst_data  = 64'h01_09_CA_FE_00_AB_0B_0C;
    inst_valid = 1'b1;
    tick();
    inst_valid = 1'b0;
    tick();
    tick();
    check("mid_wait_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    check_all_zero("async_reset");
    feature_fetch_done = 1'b1;
    tick();
    feature_fetch_done = 1'b0;
    check_all_zero("reset_hold");
    rst = 1'b1;
    ill_m = 1'b0;
    to_m  = 1'b0;
    tick();
    check("rerelease_ready", inst_ready, 1);
    check("rerelease_done", inst_done, 0);
    run_inst("after_reset", 64'h01_0A_12_12_00_CD_0C_0D, 4, 1'b0, 1'b0);

    // Random instructions.
    for (int n = 0; n < 40; n++) begin
      logic [63:0] d;
      logic [7:0]  opc;
      int          w;
      int          sel;
      d   = {$urandom, $urandom};
      sel = $urandom_range(0, 3);
      if (sel == 0) begin
        opc = 8'($urandom_range(4, 255));
        if ($urandom_range(0, 3) == 0) opc = 8'h00;
      end else begin
        opc = 8'(sel);
      end
      d[63:56] = opc;
      w = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(1, 18));
      run_inst($sformatf("rand%0d", n), d, w, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_inst_dispatch.md
# fetch_inst_dispatch

Decodes 64-bit fetch instructions from the instruction stream and drives the command ports of the feature-fetch and weight/scaler-fetch stages directly downstream of it. Issues one single-cycle enable pulse per instruction, holds the operand fields stable, waits for the matching completion, then acknowledges to the top FSM. A watchdog aborts hung fetches. Unknown opcodes are flagged and consumed.

## Interface
Parameters:
- `DONE_TIMEOUT`, 1023: max cycles spent in WAIT before abort (≥2).
- `SCALER_LAT`, 3: fixed wait cycles for scaler fetch, which has no done signal.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `inst_valid` in 1: instruction word valid.
- `inst_ready` out 1: dispatcher can accept. Reset 0; goes to 1 the first cycle after release.
- `inst_data` in 64: opcode[63:56] | f_type[55:48] | saddrh[47:40] | saddrl[39:32] | daddrh[31:24] | daddrl[23:16] | memsel[15:8] | counter[7:0].
- `feature_fetch_enable` out 1: one-cycle command pulse. Reset 0.
- `weight_fetch_enable` out 1: one-cycle command pulse. Reset 0.
- `scaler_fetch_enable` out 1: one-cycle command pulse. Reset 0.
- `fetch_type` out 8: f_type. Reset 0.
- `src_addr` out 16: {saddrh, saddrl}. Reset 0.
- `dst_addr` out 8: daddrl; daddrh is ignored. Reset 0.
- `mem_sel` out 8: memsel. Reset 0.
- `fetch_counter` out 8: counter, passed through unmodified. Reset 0.
- `feature_fetch_done` in 1: completion from the feature fetch stage.
- `weight_fetch_done` in 1: completion from the weight fetch stage.
- `inst_done` out 1: one-cycle acknowledge to the top FSM. Reset 0.
- `busy` out 1: high whenever state ≠ IDLE. Reset 0.
- `illegal_op` out 1: sticky flag. Reset 0.
- `timeout_err` out 1: sticky flag. Reset 0.
- `err_clr` in 1: synchronous clear of both sticky flags.

## Operation
Opcodes:
- `8'h01` FEATURE
- `8'h02` WEIGHT
- `8'h03` SCALER
- anything else is ILLEGAL

States:
- **IDLE**
  - `inst_ready`=1.
  - When `inst_valid` is high: latch all fields and the opcode.
  - Go to ISSUE. An ILLEGAL opcode goes to DONE instead and sets `illegal_op`.
- **ISSUE**, exactly one cycle
  - Assert the enable matching the opcode.
  - Load the watchdog with `DONE_TIMEOUT`, or with `SCALER_LAT` for SCALER.
  - Go to WAIT.
- **WAIT**, exits on the first of these:
  - FEATURE: `feature_fetch_done`=1 → DONE.
  - WEIGHT: `weight_fetch_done`=1 → DONE.
  - SCALER: watchdog reaches 0 → DONE. This is a normal completion, no error.
  - FEATURE or WEIGHT: watchdog reaches 0 → DONE and set `timeout_err`.
  - A done that arrives on the same cycle the watchdog expires counts as success; no timeout.
- **DONE**, one cycle
  - `inst_done`=1, then go to IDLE.

Rules:
- The done input of the non-selected unit is ignored.
- Any done seen in IDLE, ISSUE or DONE is ignored. It is never stored.
- Operand outputs are registered and hold their latched values from ISSUE until the next accept. They never glitch while `busy`.
- The watchdog decrements once per WAIT cycle and saturates at 0.
- `err_clr` takes priority over a set event in the same cycle.
- Reset asserted in any state, including mid-WAIT:
  - All outputs and the watchdog go to 0 and the state goes to IDLE immediately.
  - An in-flight instruction is dropped and gets no `inst_done`.

## Timing
- Accept at edge T. The enable is high during cycle T+1 (ISSUE). WAIT starts at T+2.
- Done sampled high at edge D → `inst_done` high during cycle D+1 → `inst_ready` high at D+2.
- Minimum per-instruction turnaround is 4 cycles (accept, ISSUE, 1 WAIT, DONE).
- SCALER: `inst_done` comes exactly `SCALER_LAT`+1 cycles after the ISSUE cycle.
- Timeout: `timeout_err` and DONE are entered after exactly `DONE_TIMEOUT` WAIT cycles.
- There are no combinational paths from inputs to outputs.

## Structure
- Package `fetch_dispatch_pkg` holds:
  - opcode constants `OP_FEATURE`, `OP_WEIGHT`, `OP_SCALER`;
  - the state encoding (IDLE/ISSUE/WAIT/DONE);
  - the instruction field bit positions, shared with the instruction parser.
- Sub-module `fetch_watchdog`:
  - loadable down-counter with a load value input, a decrement enable and a `zero` flag;
  - width is `$clog2(DONE_TIMEOUT+1)`.
- Top level: FSM, field latch and sticky flags, roughly 150–250 lines.

## Test plan
1. **Feature fetch.**
   - Stimulus: `inst_data`=64'h01_00_12_34_00_05_01_08; `feature_fetch_done` pulsed 10 cycles after the enable.
   - Response:
     - `feature_fetch_enable` is high for exactly 1 cycle.
     - `src_addr`=16'h1234, `dst_addr`=8'h05, `mem_sel`=8'h01, `fetch_counter`=8'h08, all stable.
     - `inst_done` pulses the cycle after done; `inst_ready` returns one cycle later.
2. **Weight fetch with a stray done.**
   - Stimulus: opcode 8'h02, src 16'h0040; a stray `feature_fetch_done` during WAIT, then `weight_fetch_done` after 3 cycles.
   - Response: the stray done is ignored; `inst_done` comes only after `weight_fetch_done`.
3. **Scaler fetch.**
   - Stimulus: opcode 8'h03 with `SCALER_LAT`=3 and no done inputs.
   - Response: `inst_done` exactly 4 cycles after the ISSUE cycle; `timeout_err` stays 0.
4. **Illegal opcode.**
   - Stimulus: opcode 8'hFF.
   - Response: no enable pulses; `illegal_op`=1; `inst_done` pulses; `inst_ready` returns. Then `err_clr` clears `illegal_op`.
5. **Timeout.**
   - Stimulus: `DONE_TIMEOUT`=15, FEATURE opcode, done withheld.
   - Response: `timeout_err`=1 and `inst_done` after 15 WAIT cycles. A late `feature_fetch_done` in IDLE is ignored and the next instruction runs normally.
6. **Reset mid-WAIT.**
   - Stimulus: assert `rst` low during WAIT.
   - Response: `busy`, all enables, `inst_done` and all operand outputs go to 0 asynchronously. After release, `inst_ready`=1 and a new FEATURE instruction completes normally.
